// File: rtl/sram_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : sram_mem_responder
// Description : MEM-stage load/store responder. Splits each 32-bit word
//               access into two 16-bit accesses on an asynchronous SRAM,
//               holding each half on the bus for WAIT_CYCLES cycles. The
//               pipeline is frozen through `ready` while an access is in
//               flight.
//               Optional macro SRAM_BOUND_CHECK_EN: reject requests outside
//               [BASE_ADDR, BASE_ADDR + 2^19) without touching the SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_mem_responder #(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,          // asynchronous, active-low
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n
);

    localparam logic [1:0]  c_IDLE    = 2'd0;
    localparam logic [1:0]  c_LO      = 2'd1;
    localparam logic [1:0]  c_HI      = 2'd2;
    localparam logic [1:0]  c_DONE    = 2'd3;

    localparam logic [31:0] c_BASE    = 32'(BASE_ADDR);
    localparam logic [3:0]  c_WAIT_M1 = 4'(WAIT_CYCLES - 1);
    // With a single-cycle phase the only cycle is also the hold cycle,
    // so the write strobe never goes low.
    localparam logic        c_MULTI   = (WAIT_CYCLES > 1);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_op_wr;
    logic [16:0] r_word;
    logic [15:0] r_wdata_hi;
    logic [31:0] r_read_data;
    logic [17:0] r_sram_addr;
    logic [15:0] r_dq_out;
    logic        r_dq_oe;
    logic        r_we_n;

    logic        w_req;
    logic [16:0] w_word;
    logic        w_reject;

    assign w_req  = wr_en | rd_en;
    // Out-of-window addresses simply wrap within the 17-bit word space.
    assign w_word = 17'((address - c_BASE) >> 2);

`ifdef SRAM_BOUND_CHECK_EN
    // Offset compared after subtraction so BASE_ADDR + 2^19 can never overflow.
    assign w_reject = (address < c_BASE) || ((address - c_BASE) >= 32'h0008_0000);
`else
    assign w_reject = 1'b0;
`endif

    // Freeze is combinational in IDLE so it takes effect in the request cycle.
    always_comb begin
        ready = 1'b0;
        if (!rst) begin
            ready = 1'b1;
        end else begin
            case (r_state)
                c_IDLE:  ready = ~w_req;
                c_DONE:  ready = 1'b1;
                default: ready = 1'b0;
            endcase
        end
    end

    // Access sequencer: state, phase timer, SRAM bus registers and load data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_IDLE;
            r_cnt       <= 4'd0;
            r_op_wr     <= 1'b0;
            r_word      <= 17'd0;
            r_wdata_hi  <= 16'd0;
            r_read_data <= 32'd0;
            r_sram_addr <= 18'd0;
            r_dq_out    <= 16'd0;
            r_dq_oe     <= 1'b0;
            r_we_n      <= 1'b1;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_req) begin
                        r_op_wr    <= wr_en;
                        r_word     <= w_word;
                        r_wdata_hi <= writeData[31:16];
                        if (w_reject) begin
                            r_state <= c_DONE;
                            if (!wr_en) begin
                                r_read_data <= 32'd0;
                            end
                        end else begin
                            r_state     <= c_LO;
                            r_cnt       <= c_WAIT_M1;
                            r_sram_addr <= {w_word, 1'b0};
                            r_dq_out    <= writeData[15:0];
                            r_dq_oe     <= wr_en;
                            r_we_n      <= ~(wr_en & c_MULTI);
                        end
                    end
                end
                c_LO: begin
                    if (r_cnt == 4'd0) begin
                        if (!r_op_wr) begin
                            r_read_data[15:0] <= sram_dq_in;
                        end
                        r_state     <= c_HI;
                        r_cnt       <= c_WAIT_M1;
                        r_sram_addr <= {r_word, 1'b1};
                        r_dq_out    <= r_wdata_hi;
                        r_dq_oe     <= r_op_wr;
                        r_we_n      <= ~(r_op_wr & c_MULTI);
                    end else begin
                        // Raise the strobe for the final cycle to give data hold.
                        r_cnt  <= r_cnt - 4'd1;
                        r_we_n <= ~(r_op_wr & (r_cnt != 4'd1));
                    end
                end
                c_HI: begin
                    if (r_cnt == 4'd0) begin
                        if (!r_op_wr) begin
                            r_read_data[31:16] <= sram_dq_in;
                        end
                        r_state <= c_DONE;
                        r_dq_oe <= 1'b0;
                        r_we_n  <= 1'b1;
                    end else begin
                        r_cnt  <= r_cnt - 4'd1;
                        r_we_n <= ~(r_op_wr & (r_cnt != 4'd1));
                    end
                end
                default: begin
                    // DONE: the request still on the inputs is the one just served.
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign readData    = r_read_data;
    assign sram_addr   = r_sram_addr;
    assign sram_dq_out = r_dq_out;
    assign sram_dq_oe  = r_dq_oe;
    assign sram_we_n   = r_we_n;

endmodule
`default_nettype wire

// File: doc/sram_mem_responder.md
Name: sram_mem_responder

Overview:
- Memory-side responder for the MEM stage's load and store requests (MEM_R_en / MEM_W_en).
- Converts one 32-bit word access into two 16-bit accesses on an external asynchronous SRAM, with programmable wait states per half.
- Drives `ready` low while busy so the pipeline freezes. `MEM_read_value` comes from `readData` and is valid in the `ready` cycle that ends a read.

Parameters:
- BASE_ADDR, 1024: byte address that maps to SRAM word 0.
- WAIT_CYCLES, 2: cycles each 16-bit half is held on the SRAM bus (legal range 1..15).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-low
- wr_en  input  1  store request from MEM stage
- rd_en  input  1  load request from MEM stage
- address  input  32  byte address (ALU result)
- writeData  input  32  store data
- readData  output  32  load data
- ready  output  1  high = idle or done; low = pipeline must freeze
- sram_addr  output  18  SRAM halfword address
- sram_dq_out  output  16  SRAM write data
- sram_dq_oe  output  1  high = drive the SRAM data bus
- sram_dq_in  input  16  SRAM read data
- sram_we_n  output  1  SRAM write strobe, active-low

Behaviour:
- Reset values: state=IDLE, wait counter=0, readData=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1, latched address/data=0.
  - Reset asserted mid-access aborts the access immediately; no further strobe is issued.
- States: IDLE, LO, HI, DONE.
- IDLE:
  - Stays in IDLE while no request is present.
  - On (wr_en | rd_en), latches op, address and writeData, then moves to LO at the next edge.
  - If both enables are high, the write wins.
  - `ready` = ~(wr_en | rd_en), combinational, so the freeze takes effect in the same cycle.
- Word address: word = (address - BASE_ADDR) >> 2, truncated to 17 bits; out-of-range addresses wrap modulo 2^17 words.
  - LO drives sram_addr = {word, 0}.
  - HI drives sram_addr = {word, 1}.
- LO and HI each last exactly WAIT_CYCLES cycles, timed by a down-counter loaded on entry.
- During a write, in both LO and HI:
  - sram_dq_oe = 1 and sram_we_n = 0 for every cycle except the last cycle of the phase.
  - In that last cycle, sram_we_n = 1 while address and data are still held (data hold time).
  - sram_dq_out = writeData[15:0] in LO and writeData[31:16] in HI.
- During a read: sram_dq_oe = 0 and sram_we_n = 1.
  - readData[15:0] captures sram_dq_in at the last edge of LO.
  - readData[31:16] captures sram_dq_in at the last edge of HI.
- DONE:
  - Lasts one cycle with ready = 1, then moves to IDLE.
  - The request still present in DONE is treated as consumed, not restarted.
- Latency: the request is seen in IDLE at cycle 0, and ready = 1 first in cycle 2*WAIT_CYCLES+1.
  - Total stall = 2*WAIT_CYCLES+1 cycles.
- readData holds its value through writes and idle periods until the next read overwrites it.
- Back-to-back requests: a request present in the IDLE cycle right after DONE starts a new access, with no gap beyond the one IDLE cycle.
- ready = 0 in LO and HI regardless of the request inputs; inputs are ignored once latched.

Optional Feature:
- Macro: SRAM_BOUND_CHECK_EN.
- When defined, a request with address < BASE_ADDR or address >= BASE_ADDR + 2^19 is rejected:
  - It goes IDLE -> DONE directly, so ready returns after 1 cycle.
  - No sram_we_n pulse is issued and sram_dq_oe stays 0.
  - A rejected read sets readData = 0.
- When not defined, there is no check and addresses wrap modulo 2^17 words as above.

Test Plan:
- Reset: rst=0 mid-write (sram_we_n=0) -> sram_we_n=1, sram_dq_oe=0, ready=1 and readData=0 on the same cycle; no further SRAM activity after release.
- Write: address=1024+8, writeData=0xDEADBEEF, WAIT=2 ->
  - sram_addr=4 with dq_out=0xBEEF, then sram_addr=5 with dq_out=0xDEAD.
  - Each half shows one we_n low cycle then one high cycle.
  - ready low for cycles 0..4 and high in cycle 5.
- Read back: same address, SRAM model returns 0xBEEF then 0xDEAD -> readData=0xDEADBEEF with ready=1 in cycle 5; value held through a following idle period.
- Both enables high with address=1024 -> write performed, readData unchanged.
- Back-to-back: write is followed immediately by a read held on the inputs -> second access starts from the IDLE cycle after DONE; exactly one write and one read are seen on the SRAM.
- SRAM_BOUND_CHECK_EN defined, rd_en with address=0 -> ready=1 after 1 cycle, readData=0, sram_we_n stays 1. Macro undefined, same stimulus -> full 5-cycle access to wrapped sram_addr.
